// File: rtl/reg_file_ctrl_if.sv
// Command and response channels between a requester and the register-file sequencer.
// The master drives commands and accepts responses; the slave is the sequencer.
interface reg_file_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
);
  logic                  Cmd_Valid;
  logic                  Cmd_Ready;
  logic                  Cmd_Wr;
  logic [ADDR_WIDTH-1:0] Cmd_Addr;
  logic [ADDR_WIDTH-1:0] Cmd_Len;
  logic [DATA_WIDTH-1:0] Cmd_Data;
  logic                  Rsp_Valid;
  logic                  Rsp_Ready;
  logic [DATA_WIDTH-1:0] Rsp_Data;
  logic [ADDR_WIDTH-1:0] Rsp_Addr;
  logic                  Rsp_Last;

  modport master (
    output Cmd_Valid, Cmd_Wr, Cmd_Addr, Cmd_Len, Cmd_Data, Rsp_Ready,
    input  Cmd_Ready, Rsp_Valid, Rsp_Data, Rsp_Addr, Rsp_Last
  );

  modport slave (
    input  Cmd_Valid, Cmd_Wr, Cmd_Addr, Cmd_Len, Cmd_Data, Rsp_Ready,
    output Cmd_Ready, Rsp_Valid, Rsp_Data, Rsp_Addr, Rsp_Last
  );
endinterface

// File: rtl/reg_file_ctrl.sv
// Sole master of an 8x16 register file: single-beat writes, wrapping burst reads
// returned one beat at a time over a valid/ready response channel.
module reg_file_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  reg_file_ctrl_if.slave        bus,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  input  logic [DATA_WIDTH-1:0] RdData
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_READ    = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t                r_state,     w_state;
  logic                  r_cmd_ready, w_cmd_ready;
  logic                  r_wr_en,     w_wr_en;
  logic                  r_rd_en,     w_rd_en;
  logic [ADDR_WIDTH-1:0] r_address,   w_address;
  logic [DATA_WIDTH-1:0] r_wr_data,   w_wr_data;
  logic                  r_rsp_valid, w_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data,  w_rsp_data;
  logic [ADDR_WIDTH-1:0] r_rsp_addr,  w_rsp_addr;
  logic                  r_rsp_last,  w_rsp_last;
  logic [ADDR_WIDTH-1:0] r_cur_addr,  w_cur_addr;
  logic [ADDR_WIDTH-1:0] r_cnt,       w_cnt;
  logic                  w_cmd_fire;
  logic [ADDR_WIDTH-1:0] w_addr_inc;

  // Cmd_Ready is only ever high in IDLE, so this alone qualifies acceptance.
  assign w_cmd_fire = bus.Cmd_Valid && r_cmd_ready;
  assign w_addr_inc = r_cur_addr + ADDR_WIDTH'(1);

  // Next-state and next-output decode.
  always_comb begin
    w_state     = r_state;
    w_cmd_ready = 1'b0;
    w_wr_en     = 1'b0;
    w_rd_en     = 1'b0;
    w_address   = r_address;
    w_wr_data   = r_wr_data;
    w_rsp_valid = r_rsp_valid;
    w_rsp_data  = r_rsp_data;
    w_rsp_addr  = r_rsp_addr;
    w_rsp_last  = r_rsp_last;
    w_cur_addr  = r_cur_addr;
    w_cnt       = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_fire) begin
          w_address = bus.Cmd_Addr;
          if (bus.Cmd_Wr) begin
            w_state   = S_WRITE;
            w_wr_en   = 1'b1;
            w_wr_data = bus.Cmd_Data;
          end else begin
            w_state    = S_READ;
            w_rd_en    = 1'b1;
            w_cur_addr = bus.Cmd_Addr;
            w_cnt      = bus.Cmd_Len;
          end
        end else begin
          w_cmd_ready = 1'b1;
        end
      end
      S_WRITE: begin
        w_state     = S_IDLE;
        w_cmd_ready = 1'b1;
      end
      S_READ: begin
        w_state = S_CAPTURE;
      end
      // RdData only becomes valid after the edge that ends the RdEn cycle.
      S_CAPTURE: begin
        w_state     = S_RESP;
        w_rsp_valid = 1'b1;
        w_rsp_data  = RdData;
        w_rsp_addr  = r_cur_addr;
        w_rsp_last  = (r_cnt == '0);
      end
      S_RESP: begin
        if (r_rsp_valid && bus.Rsp_Ready) begin
          w_rsp_valid = 1'b0;
          if (r_cnt == '0) begin
            w_state = S_IDLE;
          end else begin
            w_state    = S_READ;
            w_rd_en    = 1'b1;
            w_cur_addr = w_addr_inc;
            w_address  = w_addr_inc;
            w_cnt      = r_cnt - ADDR_WIDTH'(1);
          end
        end else begin
          w_state = S_RESP;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_address   <= '0;
      r_wr_data   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_addr  <= '0;
      r_rsp_last  <= 1'b0;
      r_cur_addr  <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state;
      r_cmd_ready <= w_cmd_ready;
      r_wr_en     <= w_wr_en;
      r_rd_en     <= w_rd_en;
      r_address   <= w_address;
      r_wr_data   <= w_wr_data;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_data  <= w_rsp_data;
      r_rsp_addr  <= w_rsp_addr;
      r_rsp_last  <= w_rsp_last;
      r_cur_addr  <= w_cur_addr;
      r_cnt       <= w_cnt;
    end
  end

  assign bus.Cmd_Ready = r_cmd_ready;
  assign bus.Rsp_Valid = r_rsp_valid;
  assign bus.Rsp_Data  = r_rsp_data;
  assign bus.Rsp_Addr  = r_rsp_addr;
  assign bus.Rsp_Last  = r_rsp_last;
  assign WrEn          = r_wr_en;
  assign RdEn          = r_rd_en;
  assign Address       = r_address;
  assign WrData        = r_wr_data;

endmodule
